// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: load/store memory stage on a req/gnt/rvalid bus, with registered writeback outputs.
// Revision 1.0
`default_nettype none

module mem_lsu_stage #(
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int RSP_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [31:0]       reg_wdata_i,
  input  logic              reg_we_i,
  input  logic [REG_AW-1:0] reg_waddr_i,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  output logic [3:0]        bus_be_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              wb_valid_o,
  output logic [31:0]       reg_wdata_o,
  output logic              reg_we_o,
  output logic [REG_AW-1:0] reg_waddr_o,
  output logic              jump_flag_o,
  output logic [31:0]       jump_addr_o,
  output logic              misalign_o,
  output logic              access_err_o
);

  localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] q_addr;
  logic              q_store;
  logic [3:0]        q_be;
  logic [31:0]       q_wdata;
  logic [2:0]        q_funct3;
  logic [1:0]        q_off;
  logic [REG_AW-1:0] q_waddr;
  logic              q_regwe;
  logic              q_jf;
  logic [31:0]       q_ja;

  logic        is_mem, ld_ok, st_ok, illegal, misaligned, issue, tmo;
  logic [3:0]  in_be;
  logic [31:0] in_wd, lane, ld_ext;

  assign is_mem     = valid_i & (load_i | store_i);
  assign ld_ok      = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign st_ok      = funct3_i inside {3'b000, 3'b001, 3'b010};
  assign illegal    = (load_i & store_i) | (load_i & ~ld_ok) | (store_i & ~st_ok);
  assign misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                      ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
  // Gating with rst keeps the bus quiet while reset is held, even with a stalled instruction still presented.
  assign issue      = rst & (state == S_IDLE) & is_mem & ~illegal & ~misaligned;
  assign tmo        = (RSP_TIMEOUT != 0) && (cnt == CW'(RSP_TIMEOUT - 1));

  always_comb begin
    in_be = 4'b1111;
    in_wd = '0;
    if (store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          in_be = 4'b0001 << addr_i[1:0];
          in_wd = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          in_be = 4'b0011 << addr_i[1:0];
          in_wd = {2{store_data_i[15:0]}};
        end
        default: in_wd = store_data_i;
      endcase
    end
  end

  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_be_o    = '0;
    if (issue) begin
      bus_req_o   = 1'b1;
      bus_we_o    = store_i;
      bus_addr_o  = {addr_i[ADDR_W-1:2], 2'b00};
      bus_wdata_o = in_wd;
      bus_be_o    = in_be;
    end else if (state == S_REQ) begin
      bus_req_o   = 1'b1;
      bus_we_o    = q_store;
      bus_addr_o  = q_addr;
      bus_wdata_o = q_wdata;
      bus_be_o    = q_be;
    end
  end

  assign stall_o = issue |
                   ((state == S_REQ)  & ~(tmo & ~bus_gnt_i)) |
                   ((state == S_WAIT) & ~bus_rvalid_i & ~tmo);

  assign lane = bus_rdata_i >> {q_off, 3'b000};

  always_comb begin
    case (q_funct3)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'd0, lane[7:0]};
      3'b101:  ld_ext = {16'd0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      q_addr       <= '0;
      q_store      <= 1'b0;
      q_be         <= '0;
      q_wdata      <= '0;
      q_funct3     <= '0;
      q_off        <= '0;
      q_waddr      <= '0;
      q_regwe      <= 1'b0;
      q_jf         <= 1'b0;
      q_ja         <= '0;
      wb_valid_o   <= 1'b0;
      reg_wdata_o  <= '0;
      reg_we_o     <= 1'b0;
      reg_waddr_o  <= '0;
      jump_flag_o  <= 1'b0;
      jump_addr_o  <= '0;
      misalign_o   <= 1'b0;
      access_err_o <= 1'b0;
    end else begin
      wb_valid_o   <= 1'b0;
      reg_we_o     <= 1'b0;
      jump_flag_o  <= 1'b0;
      misalign_o   <= 1'b0;
      access_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (!is_mem || illegal || misaligned) begin
              wb_valid_o   <= 1'b1;
              reg_wdata_o  <= reg_wdata_i;
              reg_we_o     <= reg_we_i & ~is_mem;
              reg_waddr_o  <= reg_waddr_i;
              jump_flag_o  <= jump_flag_i;
              jump_addr_o  <= jump_addr_i;
              misalign_o   <= is_mem & ~illegal & misaligned;
              access_err_o <= is_mem & illegal;
            end else begin
              q_addr   <= {addr_i[ADDR_W-1:2], 2'b00};
              q_store  <= store_i;
              q_be     <= in_be;
              q_wdata  <= in_wd;
              q_funct3 <= funct3_i;
              q_off    <= addr_i[1:0];
              q_waddr  <= reg_waddr_i;
              q_regwe  <= reg_we_i & load_i;
              q_jf     <= jump_flag_i;
              q_ja     <= jump_addr_i;
              cnt      <= '0;
              state    <= bus_gnt_i ? S_WAIT : S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_gnt_i) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else if (tmo) begin
            wb_valid_o   <= 1'b1;
            access_err_o <= 1'b1;
            reg_waddr_o  <= q_waddr;
            jump_flag_o  <= q_jf;
            jump_addr_o  <= q_ja;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus_rvalid_i) begin
            wb_valid_o  <= 1'b1;
            reg_wdata_o <= q_store ? 32'd0 : ld_ext;
            reg_we_o    <= q_regwe;
            reg_waddr_o <= q_waddr;
            jump_flag_o <= q_jf;
            jump_addr_o <= q_ja;
            state       <= S_IDLE;
          end else if (tmo) begin
            wb_valid_o   <= 1'b1;
            access_err_o <= 1'b1;
            reg_waddr_o  <= q_waddr;
            jump_flag_o  <= q_jf;
            jump_addr_o  <= q_ja;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu_stage.sv
// tb_mem_lsu_stage: scoreboard bench for mem_lsu_stage (RSP_TIMEOUT = 4).
`default_nettype none

module tb_mem_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, load_i, store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i, reg_wdata_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        stall_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        wb_valid_o, reg_we_o, jump_flag_o, misalign_o, access_err_o;
  logic [31:0] reg_wdata_o, jump_addr_o;
  logic [4:0]  reg_waddr_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] wd;
    logic        we;
    logic [4:0]  wa;
    logic        mis;
    logic        err;
    logic        jf;
    logic [31:0] ja;
  } exp_t;
  exp_t sb[$];

  mem_lsu_stage #(.ADDR_W(32), .REG_AW(5), .RSP_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .load_i(load_i), .store_i(store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .reg_wdata_i(reg_wdata_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .stall_o(stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .wb_valid_o(wb_valid_o),
    .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .misalign_o(misalign_o),
    .access_err_o(access_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] wd, input logic we, input logic mis, input logic err);
    exp_t e;
    e.wd = wd; e.we = we; e.wa = reg_waddr_i; e.mis = mis; e.err = err;
    e.jf = jump_flag_i; e.ja = jump_addr_i;
    sb.push_back(e);
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] wa);
    valid_i = 1'b1; load_i = ld; store_i = st; funct3_i = f3; addr_i = addr;
    store_data_i = sd; reg_wdata_i = 32'h5555_AAAA; reg_we_i = 1'b1; reg_waddr_i = wa;
  endtask

  // gd = cycles before gnt is given, rd = WAIT cycles before rvalid arrives
  task automatic do_mem(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] wa,
                        input int gd, input int rd, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_res);
    drive(ld, st, f3, addr, sd, wa);
    push(exp_res, ld, 1'b0, 1'b0);
    bus_gnt_i = (gd == 0);
    for (int i = 0; i <= gd; i++) begin
      @(negedge clk);
      check_eq({nm, "_req"}, bus_req_o, 1);
      check_eq({nm, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
      check_eq({nm, "_be"}, bus_be_o, exp_be);
      check_eq({nm, "_we"}, bus_we_o, st);
      if (st) check_eq({nm, "_wdata"}, bus_wdata_o, exp_wd);
      check_eq({nm, "_stall_req"}, stall_o, 1);
      @(posedge clk);
      #1;
      bus_gnt_i = (i + 1 == gd);
    end
    for (int j = 0; j < rd; j++) begin
      @(negedge clk);
      check_eq({nm, "_req_wait"}, bus_req_o, 0);
      check_eq({nm, "_stall_wait"}, stall_o, 1);
      @(posedge clk);
      #1;
    end
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = rdata;
    @(negedge clk);
    check_eq({nm, "_stall_rvalid"}, stall_o, 0);
    @(posedge clk);
    #1;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'hDEAD_DEAD;
    valid_i = 1'b0;
    idle(1);
  endtask

  task automatic err_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic mis, input logic err);
    drive(ld, st, f3, addr, 32'h1111_2222, 5'd9);
    push(32'h0, 1'b0, mis, err);
    @(negedge clk);
    check_eq({nm, "_noreq"}, bus_req_o, 0);
    check_eq({nm, "_nostall"}, stall_o, 0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    idle(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (wb_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("wb_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        if (e.we) check_eq("wb_data", reg_wdata_o, e.wd);
        check_eq("wb_we", reg_we_o, e.we);
        check_eq("wb_waddr", reg_waddr_o, e.wa);
        check_eq("wb_misalign", misalign_o, e.mis);
        check_eq("wb_err", access_err_o, e.err);
        check_eq("wb_jflag", jump_flag_o, e.jf);
        check_eq("wb_jaddr", jump_addr_o, e.ja);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; valid_i = 0; load_i = 0; store_i = 0; funct3_i = 0; addr_i = 0;
    store_data_i = 0; reg_wdata_i = 0; reg_we_i = 0; reg_waddr_i = 0;
    jump_flag_i = 0; jump_addr_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    idle(2);
    @(negedge clk);
    check_eq("rst_ctrl", {stall_o, bus_req_o, bus_we_o, wb_valid_o, reg_we_o,
                          misalign_o, access_err_o, jump_flag_o}, 0);
    check_eq("rst_bus", bus_addr_o | bus_wdata_o | {28'd0, bus_be_o}, 0);
    check_eq("rst_wb", reg_wdata_o | jump_addr_o | {27'd0, reg_waddr_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // ALU op with a jump attached
    valid_i = 1; load_i = 0; store_i = 0; reg_wdata_i = 32'h1234; reg_waddr_i = 5;
    reg_we_i = 1; jump_flag_i = 1; jump_addr_i = 32'h0000_0400;
    push(32'h1234, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("alu_stall", stall_o, 0);
    check_eq("alu_noreq", bus_req_o, 0);
    @(posedge clk);
    #1;
    valid_i = 0;
    idle(2);

    // Loads; the first carries a jump through the stall
    jump_flag_i = 1; jump_addr_i = 32'h8000_0040;
    do_mem("lb",  1, 0, 3'b000, 32'h1003, 0, 5'd7, 0, 2, 32'h80FF_0000, 4'b1111, 0, 32'hFFFF_FF80);
    jump_flag_i = 0; jump_addr_i = 0;
    do_mem("lbu", 1, 0, 3'b100, 32'h1003, 0, 5'd8, 0, 2, 32'h80FF_0000, 4'b1111, 0, 32'h0000_0080);
    do_mem("lh",  1, 0, 3'b001, 32'h1002, 0, 5'd9, 1, 0, 32'h80FF_0000, 4'b1111, 0, 32'hFFFF_80FF);
    do_mem("lhu", 1, 0, 3'b101, 32'h1002, 0, 5'd10, 0, 1, 32'h80FF_0000, 4'b1111, 0, 32'h0000_80FF);
    do_mem("lw",  1, 0, 3'b010, 32'h1000, 0, 5'd11, 2, 1, 32'h1234_5678, 4'b1111, 0, 32'h1234_5678);
    do_mem("lb0", 1, 0, 3'b000, 32'h1000, 0, 5'd12, 0, 0, 32'h0000_007F, 4'b1111, 0, 32'h0000_007F);

    // Stores
    do_mem("sh", 0, 1, 3'b001, 32'h2002, 32'hABCD_BEEF, 5'd13, 3, 0, 0, 4'b1100, 32'hBEEF_BEEF, 0);
    do_mem("sb", 0, 1, 3'b000, 32'h2001, 32'h0000_00A5, 5'd14, 0, 1, 0, 4'b0010, 32'hA5A5_A5A5, 0);
    do_mem("sw", 0, 1, 3'b010, 32'h3000, 32'hCAFE_F00D, 5'd15, 1, 1, 0, 4'b1111, 32'hCAFE_F00D, 0);

    // Check failures
    err_op("lw_mis",  1, 0, 3'b010, 32'h1002, 1, 0);
    err_op("sh_mis",  0, 1, 3'b001, 32'h2001, 1, 0);
    err_op("ld_f3",   1, 0, 3'b011, 32'h1000, 0, 1);
    err_op("st_f3",   0, 1, 3'b100, 32'h1000, 0, 1);
    err_op("ld_st",   1, 1, 3'b010, 32'h1000, 0, 1);

    // Timeout in WAIT, then a late rvalid that must be ignored
    drive(1, 0, 3'b010, 32'h1000, 0, 5'd16);
    push(32'h0, 1'b0, 1'b0, 1'b1);
    bus_gnt_i = 1;
    @(negedge clk);
    check_eq("to_req", bus_req_o, 1);
    @(posedge clk);
    #1;
    bus_gnt_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("to_stall", stall_o, (i < 3) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    valid_i = 0;
    idle(2);
    bus_rvalid_i = 1;
    idle(1);
    bus_rvalid_i = 0;
    idle(2);

    // Reset during WAIT aborts the access
    drive(1, 0, 3'b010, 32'h1000, 0, 5'd17);
    bus_gnt_i = 1;
    @(posedge clk);
    #1;
    bus_gnt_i = 0;
    @(negedge clk);
    check_eq("rwait_stall", stall_o, 1);
    rst = 1'b0;
    #1;
    check_eq("rwait_out", {stall_o, bus_req_o, wb_valid_o, reg_we_o, access_err_o}, 0);
    @(posedge clk);
    #1;
    valid_i = 0;
    bus_rvalid_i = 1;
    idle(1);
    bus_rvalid_i = 0;
    rst = 1'b1;
    idle(1);
    do_mem("sw_rst", 0, 1, 3'b010, 32'h3004, 32'h0BAD_CAFE, 5'd18, 0, 1, 0, 4'b1111, 32'h0BAD_CAFE, 0);

    idle(3);
    check_eq("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
